// File: rtl/vram_arbiter.sv
// ============================================================================
// Module      : vram_arbiter
// Description : Memory-clock arbiter/responder for a 16-bit async SRAM.
//               Video fetch port has priority; the CPU port gets a slot once
//               a bounded video burst has elapsed while it waits.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int VBURST_MAX = 8
) (
    input  logic          mclk,
    input  logic          rst,
    input  logic [AW-1:0] vaddr,
    input  logic          v_req,
    output logic          v_req_en,
    output logic [DW-1:0] v_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [1:0]    cpu_be,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_dout,
    output logic          sram_doe,
    input  logic [DW-1:0] sram_din,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    localparam logic [7:0] BURST_LIM = 8'(VBURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VRD  = 3'd1,
        S_CRD  = 3'd2,
        S_CWS  = 3'd3,
        S_CWP  = 3'd4,
        S_CWH  = 3'd5,
        S_CACK = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      bcnt;
    logic [7:0]      bcnt_nxt;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [1:0]      req_be;
    logic            arb;
    logic            cpu_req_eff;
    logic            v_grant;
    logic            cpu_accept;

    // Arbitration decision; the requester only sees cpu_ack after the CACK
    // edge, so cpu_req is ignored during CACK to avoid replaying the access.
    always_comb begin
        arb         = !rst && (state == S_IDLE || state == S_VRD || state == S_CACK);
        cpu_req_eff = cpu_req && (state != S_CACK);
        v_grant     = arb && v_req && !(cpu_req_eff && bcnt == BURST_LIM);
        cpu_accept  = arb && !v_grant && cpu_req_eff;
    end

    // Next-state and SRAM strobe decode; CPU-state pins come from captured registers.
    always_comb begin
        state_nxt = S_IDLE;
        v_req_en  = v_grant;
        cpu_ack   = 1'b0;
        sram_addr = req_addr;
        sram_dout = req_wdata;
        sram_doe  = 1'b0;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        case (state)
            S_IDLE, S_VRD, S_CACK: begin
                cpu_ack = (state == S_CACK) && !rst;
                if (v_grant) begin
                    state_nxt = S_VRD;
                    sram_addr = vaddr;
                    sram_oe_n = 1'b0;
                    sram_ub_n = 1'b0;
                    sram_lb_n = 1'b0;
                end else if (cpu_accept) begin
                    state_nxt = cpu_we ? S_CWS : S_CRD;
                end
            end
            S_CRD: begin
                state_nxt = S_CACK;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            S_CWS: begin
                state_nxt = S_CWP;
                sram_doe  = 1'b1;
            end
            S_CWP: begin
                state_nxt = S_CWH;
                sram_doe  = 1'b1;
                sram_we_n = 1'b0;
                sram_ub_n = ~req_be[1];
                sram_lb_n = ~req_be[0];
            end
            S_CWH: begin
                state_nxt = S_CACK;
                sram_doe  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst counter: counts video grants that the CPU has been waiting through.
    always_comb begin
        bcnt_nxt = 8'd0;
        if (arb && !cpu_accept && cpu_req_eff) begin
            bcnt_nxt = bcnt;
            if (v_grant && bcnt != BURST_LIM) begin
                bcnt_nxt = bcnt + 8'd1;
            end
        end
    end

    // State, counter, read-data capture and CPU request capture.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state     <= S_IDLE;
            bcnt      <= 8'd0;
            v_data    <= '0;
            cpu_rdata <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= 2'b00;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            if (v_grant) begin
                v_data <= sram_din;
            end
            if (state == S_CRD) begin
                cpu_rdata <= sram_din;
            end
            if (cpu_accept) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_be    <= cpu_be;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with an
//               async-SRAM model behind the pads.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic [17:0] vaddr = '0;
    logic        v_req = 1'b0;
    logic        v_req_en;
    logic [15:0] v_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [17:0] cpu_addr = '0;
    logic [1:0]  cpu_be = 2'b00;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [17:0] sram_addr;
    logic [15:0] sram_dout;
    logic        sram_doe;
    logic [15:0] sram_din;
    logic        sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:1023];
    bit          loaded = 1'b0;

    vram_arbiter #(.AW(18), .DW(16), .VBURST_MAX(8)) dut (
        .mclk(mclk), .rst(rst), .vaddr(vaddr), .v_req(v_req), .v_req_en(v_req_en),
        .v_data(v_data), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
        .sram_din(sram_din), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 mclk = ~mclk;

    // Async SRAM read path.
    assign sram_din = sram_oe_n ? 16'h0000 : mem[sram_addr[9:0]];

    // SRAM model: preload k^A5A5, then commit byte lanes at the end of a WE-low cycle.
    always @(posedge mclk) begin
        if (!loaded) begin
            for (int k = 0; k < 1024; k++) mem[k] <= 16'(k) ^ 16'hA5A5;
            loaded <= 1'b1;
        end else if (!rst && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dout[15:8];
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dout[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pads must never be driven while the SRAM drives dq.
    always @(negedge mclk) begin
        if (!rst && sram_doe) check("doe_vs_oe", {31'b0, sram_oe_n}, 32'd1);
    end

    // One CPU access from posedge+1; reports contiguous video grants from the
    // start, the cycle index of cpu_ack and WE-pulse observations.
    task automatic run_cpu(input logic we, input logic [17:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, output int grants, output int ack_at,
                           output int we_cycles, output logic ub_p, output logic lb_p,
                           output logic [15:0] rd);
        bit run = 1'b1;
        grants = 0; ack_at = -1; we_cycles = 0; ub_p = 1'b1; lb_p = 1'b1; rd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        for (int i = 0; i < 40 && ack_at < 0; i++) begin
            @(negedge mclk);
            if (run && v_req_en) grants++; else run = 1'b0;
            if (!sram_we_n) begin
                we_cycles++; ub_p = sram_ub_n; lb_p = sram_lb_n;
            end
            if (cpu_ack) begin
                ack_at = i; rd = cpu_rdata;
            end
            @(posedge mclk); #1;
        end
        cpu_req = 1'b0;
        if (ack_at < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    int          g, a, w;
    logic        ub, lb;
    logic [15:0] rd;

    initial begin
        // Reset, with a video request pending that must not be granted.
        v_req = 1'b1;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check("rst_v_req_en", {31'b0, v_req_en}, 32'd0);
        check("rst_cpu_ack",  {31'b0, cpu_ack}, 32'd0);
        check("rst_v_data",   {16'b0, v_data}, 32'd0);
        check("rst_cpu_rdata",{16'b0, cpu_rdata}, 32'd0);
        check("rst_strobes",  {27'b0, sram_we_n, sram_oe_n, sram_doe, sram_ub_n, sram_lb_n}, 32'h1B);
        @(posedge mclk); #1;
        rst = 1'b0; v_req = 1'b0;
        @(posedge mclk); #1;

        // Streaming video reads: one word per cycle, data one cycle after grant.
        v_req = 1'b1;
        for (int k = 0; k < 256; k++) begin
            vaddr = 18'(k);
            @(negedge mclk);
            check("vid_grant", {31'b0, v_req_en}, 32'd1);
            if (k > 0) check("vid_data", {16'b0, v_data}, {16'b0, 16'(k - 1) ^ 16'hA5A5});
            @(posedge mclk); #1;
        end
        v_req = 1'b0;
        @(negedge mclk);
        check("vid_last_data", {16'b0, v_data}, 32'h0000A55A);
        check("vid_no_grant", {31'b0, v_req_en}, 32'd0);
        @(posedge mclk); #1;
        @(negedge mclk);
        check("vid_data_hold", {16'b0, v_data}, 32'h0000A55A);
        @(posedge mclk); #1;

        // CPU read under saturated video: 8 grants, 2 dead cycles, ack.
        vaddr = 18'd20; v_req = 1'b1;
        repeat (2) begin @(posedge mclk); #1; end
        run_cpu(1'b0, 18'h100, 2'b11, 16'h0, g, a, w, ub, lb, rd);
        check("burst_grants", g, 32'd8);
        check("burst_ack_at", a, 32'd10);
        check("burst_rdata", {16'b0, rd}, 32'h0000A4A5);
        v_req = 1'b0;
        @(posedge mclk); #1;

        // Byte-lane write: fill with FFFF, write 1234 upper lane only, read back.
        run_cpu(1'b1, 18'h3, 2'b11, 16'hFFFF, g, a, w, ub, lb, rd);
        check("wr_full_ack_at", a, 32'd4);
        run_cpu(1'b1, 18'h3, 2'b10, 16'h1234, g, a, w, ub, lb, rd);
        check("wr_be10_ack_at", a, 32'd4);
        check("wr_we_cycles", w, 32'd1);
        check("wr_lb_n_pulse", {31'b0, lb}, 32'd1);
        check("wr_ub_n_pulse", {31'b0, ub}, 32'd0);
        run_cpu(1'b0, 18'h3, 2'b11, 16'h0, g, a, w, ub, lb, rd);
        check("rd_ack_at", a, 32'd2);
        check("rd_be10_data", {16'b0, rd}, 32'h000012FF);

        // Write with no lanes enabled still acks and leaves memory alone.
        run_cpu(1'b1, 18'h7, 2'b00, 16'h5555, g, a, w, ub, lb, rd);
        check("wr_be00_ack_at", a, 32'd4);
        check("wr_be00_lanes", {30'b0, ub, lb}, 32'd3);
        run_cpu(1'b0, 18'h7, 2'b11, 16'h0, g, a, w, ub, lb, rd);
        check("rd_be00_data", {16'b0, rd}, 32'h0000A5A2);

        // Video and CPU rise together: video wins the burst first.
        @(posedge mclk); #1;
        vaddr = 18'd40; v_req = 1'b1;
        run_cpu(1'b0, 18'h5, 2'b11, 16'h0, g, a, w, ub, lb, rd);
        check("same_cycle_grants", g, 32'd8);
        check("same_cycle_ack_at", a, 32'd10);
        check("same_cycle_rdata", {16'b0, rd}, 32'h0000A5A0);
        v_req = 1'b0;
        @(posedge mclk); #1;

        // Reset during the WE pulse aborts the write without an ack.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h9; cpu_be = 2'b11; cpu_wdata = 16'hBEEF;
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        rst = 1'b1;
        @(negedge mclk);
        check("rst_wr_pulse_seen", {31'b0, sram_we_n}, 32'd0);
        @(posedge mclk); #1;
        cpu_req = 1'b0;
        @(negedge mclk);
        check("rst_wr_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_wr_doe", {31'b0, sram_doe}, 32'd0);
        check("rst_wr_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_wr_ack", {31'b0, cpu_ack}, 32'd0);
        @(posedge mclk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            check("rst_wr_no_ack", {31'b0, cpu_ack}, 32'd0);
            @(posedge mclk); #1;
        end
        run_cpu(1'b0, 18'h9, 2'b11, 16'h0, g, a, w, ub, lb, rd);
        check("rst_wr_mem_kept", {16'b0, rd}, 32'h0000A5AC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
